serial_nibble_loader: RTL



---
 rtl/serial_nibble_loader_pkg.sv | 26 ++
 rtl/serial_nibble_loader.sv | 118 +++++++++++
 2 files changed

// File: rtl/serial_nibble_loader_pkg.sv
// Shared types and widths for the serial-to-nibble loader.
// The bit-insertion helper keeps bit ordering in one place.
package serial_nibble_loader_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int NIB_W    = 4;
    localparam int BITCNT_W = 2;
    localparam int NIBCNT_W = 8;

    // MSB-first shifts left so the first bit ends in bit 3; LSB-first shifts right.
    function automatic logic [NIB_W-1:0] shift_in(
        input logic [NIB_W-1:0] cur,
        input logic             bit_in,
        input logic             msb_first
    );
        if (msb_first)
            return {cur[NIB_W-2:0], bit_in};
        else
            return {bit_in, cur[NIB_W-1:1]};
    endfunction

endpackage

// File: rtl/serial_nibble_loader.sv
// Deserialises a framed serial stream into nibbles, presenting each on D0..D3
// with a one-cycle CE strobe; tracks frame length and flags framing errors.
module serial_nibble_loader
    import serial_nibble_loader_pkg::*;
#(
    parameter bit MSB_FIRST     = 1'b1,
    parameter int FRAME_NIBBLES = 0
) (
    input  logic C,
    input  logic CLR,
    input  logic SI,
    input  logic SV,
    input  logic SOF,
    input  logic ERR_CLR,
    output logic D0,
    output logic D1,
    output logic D2,
    output logic D3,
    output logic CE,
    output logic BUSY,
    output logic ERR
);

    localparam logic [NIBCNT_W-1:0] FRAME_LEN = NIBCNT_W'(FRAME_NIBBLES);
    localparam bit                  BOUNDED   = (FRAME_NIBBLES != 0);
    localparam logic [NIBCNT_W-1:0] NIB_MAX   = '1;
    localparam logic [BITCNT_W-1:0] LAST_BIT  = '1;

    state_t                state, state_nxt;
    logic [BITCNT_W-1:0]   bit_cnt, bit_cnt_nxt, bit_base;
    logic [NIBCNT_W-1:0]   nib_cnt, nib_cnt_nxt, nib_base, nib_inc;
    logic [NIB_W-1:0]      sreg, sreg_nxt, nib_q;
    logic                  accept, load, err_set, ce_q, err_q;

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        nib_cnt_nxt = nib_cnt;
        sreg_nxt    = sreg;
        bit_base    = bit_cnt;
        nib_base    = nib_cnt;
        nib_inc     = nib_cnt;
        accept      = 1'b0;
        load        = 1'b0;
        err_set     = 1'b0;

        case (state)
            IDLE: begin
                if (SOF) begin
                    state_nxt = SHIFT;
                    accept    = 1'b1;
                    bit_base  = '0;
                    nib_base  = '0;
                end
            end
            SHIFT: begin
                accept = 1'b1;
                if (SOF) begin
                    // Restarting is always honoured; it is only an error if work is lost.
                    err_set  = (bit_cnt != '0) || (BOUNDED && (nib_cnt != '0));
                    bit_base = '0;
                    nib_base = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (accept) begin
            bit_cnt_nxt = bit_base;
            nib_cnt_nxt = nib_base;
            if (SV) begin
                sreg_nxt    = shift_in(sreg, SI, MSB_FIRST);
                bit_cnt_nxt = bit_base + 1'b1;
                if (bit_base == LAST_BIT) begin
                    load        = 1'b1;
                    nib_inc     = (nib_base == NIB_MAX) ? nib_base : nib_base + 1'b1;
                    nib_cnt_nxt = nib_inc;
                    if (BOUNDED && (nib_inc == FRAME_LEN))
                        state_nxt = IDLE;
                end
            end
        end
    end

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            bit_cnt <= '0;
            nib_cnt <= '0;
            sreg    <= '0;
            nib_q   <= '0;
            ce_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            bit_cnt <= bit_cnt_nxt;
            nib_cnt <= nib_cnt_nxt;
            sreg    <= sreg_nxt;
            ce_q    <= load;
            if (load)
                nib_q <= sreg_nxt;
            // A same-cycle set beats ERR_CLR.
            if (err_set)
                err_q <= 1'b1;
            else if (ERR_CLR)
                err_q <= 1'b0;
        end
    end

    assign {D3, D2, D1, D0} = nib_q;
    assign CE   = ce_q;
    assign BUSY = (state == SHIFT);
    assign ERR  = err_q;

endmodule
